// File: rtl/dm_if.sv
// dm_if - handshake bundle between the MEM-stage requester and dm_responder.
//   req    requester -> responder  request valid, held until ack
//   we     requester -> responder  1 = store, 0 = load
//   addr   requester -> responder  byte address
//   be     requester -> responder  store byte enables
//   wdata  requester -> responder  store data
//   rdata  responder -> requester  load data, valid while ack
//   ack    responder -> requester  one-cycle completion pulse
//   busy   responder -> requester  request in flight
interface dm_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack, busy
  );
endinterface

// File: rtl/dm_responder.sv
// dm_responder - fixed-latency data-memory responder for a stalling MEM stage.
// Accepts one load/store at a time, commits it LATENCY cycles after accept,
// then pulses ack for one cycle. Holds 2^ADDR_W 32-bit words, all cleared by
// reset.
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    dm_if slave modport (req/we/addr/be/wdata in, rdata/ack/busy out)
//
// state | meaning
// IDLE  | waiting for req; request fields latched on accept
// WAIT  | counting down cnt; access commits when cnt reaches 0
// RESP  | ack high for this single cycle; req ignored
module dm_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  dm_if.slave  bus
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         mem_d [DEPTH];
  logic [31:0]         merged;

  // Byte offset and upper address bits are deliberately dropped: addresses
  // alias modulo the memory depth and no misalignment is reported.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end

  // Store data merged over the currently stored word under the byte enables
  always_comb begin
    merged = mem_q[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Next-state / datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    mem_d   = mem_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          be_d    = bus.be;
          wdata_d = bus.wdata;
          idx_d   = bus.addr[ADDR_W+1:2];
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (we_q) mem_d[idx_q] = merged;
          else      rdata_d      = mem_q[idx_q];
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // busy follows the registered state so it rises on accept and falls with ack
    busy_d = (state_d != S_IDLE);
  end

  // Outputs
  always_comb begin
    bus.ack   = (state_q == S_RESP);
    bus.busy  = busy_q;
    bus.rdata = rdata_q;
  end

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] last_load;

  dm_if bus ();

  dm_responder #(.ADDR_W(10), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request starting just after a rising edge; checks latency,
  // busy duration, single ack pulse and rdata at ack.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
    int  lat;
    int  busy_n;
    bit  got;
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.be    = b;
    bus.wdata = d;
    @(posedge clk); #1;
    chk({tag, "_busy_acc"}, 32'(bus.busy), 32'd1);
    chk({tag, "_ack_acc"},  32'(bus.ack),  32'd0);
    lat    = 0;
    busy_n = 1;
    got    = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_n++;
      if (bus.ack)  got = 1'b1;
    end
    chk({tag, "_lat"},   32'(lat),  32'(LATENCY));
    chk({tag, "_rdata"}, bus.rdata, exp_rd);
    bus.req = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ack_off"},  32'(bus.ack),  32'd0);
    chk({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    chk({tag, "_busy_n"},   32'(busy_n),   32'(LATENCY + 1));
  endtask

  initial begin
    int acks;
    int ack_at [2];
    reset     = 1'b1;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.be    = '0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",   32'(bus.ack),  32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_rdata", bus.rdata,     32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    last_load = 32'h0;
    do_req(1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h0000_0000, "ld10");

    do_req(1'b1, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF, last_load, "st40");
    do_req(1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'hDEAD_BEEF, "ld40");
    last_load = 32'hDEAD_BEEF;

    do_req(1'b1, 32'h0000_0040, 4'b0101, 32'h1122_3344, last_load, "st40p");
    do_req(1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'hDE22_BE44, "ld40p");
    last_load = 32'hDE22_BE44;

    do_req(1'b1, 32'h0000_1004, 4'hF, 32'h1234_5678, last_load, "st1004");
    do_req(1'b0, 32'h0000_0004, 4'hF, 32'h0, 32'h1234_5678, "ld04");
    do_req(1'b0, 32'h0000_0007, 4'hF, 32'h0, 32'h1234_5678, "ld07");
    last_load = 32'h1234_5678;

    do_req(1'b1, 32'h0000_0040, 4'h0, 32'hFFFF_FFFF, last_load, "st40z");
    do_req(1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'hDE22_BE44, "ld40z");

    // req held high across two back-to-back loads
    acks      = 0;
    ack_at[0] = 0;
    ack_at[1] = 0;
    bus.req   = 1'b1;
    bus.we    = 1'b0;
    bus.addr  = 32'h0000_0040;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 4) chk("held_busy_gap", 32'(bus.busy), 32'd0);
      if (i == 5) chk("held_busy_acc2", 32'(bus.busy), 32'd1);
      if (bus.ack) begin
        if (acks < 2) ack_at[acks] = i;
        if (acks == 0) begin
          chk("held_rd1", bus.rdata, 32'hDE22_BE44);
          bus.addr = 32'h0000_0004;
        end else if (acks == 1) begin
          chk("held_rd2", bus.rdata, 32'h1234_5678);
          bus.req = 1'b0;
        end
        acks++;
      end
    end
    bus.req = 1'b0;
    chk("held_acks", 32'(acks),      32'd2);
    chk("held_ack1", 32'(ack_at[0]), 32'd3);
    chk("held_ack2", 32'(ack_at[1]), 32'd7);

    // reset while a store is waiting to commit
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'h0000_0020;
    bus.be    = 4'hF;
    bus.wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    chk("rstw_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstw_busy", 32'(bus.busy), 32'd0);
    chk("rstw_ack",  32'(bus.ack),  32'd0);
    bus.we = 1'b0;
    acks   = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.ack) acks++;
    end
    chk("rstw_no_ack", 32'(acks), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    // req already high when reset drops: accept at the next edge
    do_req(1'b0, 32'h0000_0020, 4'hF, 32'h0, 32'h0000_0000, "ld20_rst");
    do_req(1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'h0000_0000, "ld40_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Responder side of the data-memory interface driven by the MEM pipeline stage. It accepts one word-wide load or store request at a time over a req/ack handshake and services it after a fixed, parameterised latency. Stores can be partial via byte enables. It holds 2^ADDR_W words and replaces the single-cycle data memory when the pipeline is built with a stalling memory model; the requester stalls until `ack`.

## Interface
- `ADDR_W`, 10: word-address width; memory depth is 2^ADDR_W words.
- `LATENCY`, 2: cycles from request accept to access commit; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  1  request valid; held by the requester until `ack`.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `addr`  in  32  byte address; only `addr[ADDR_W+1:2]` is used.
- `be`  in  4  byte enables for stores; bit i enables `wdata[8i+7:8i]`; ignored for loads.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data; valid while `ack`=1.
- `ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from accept until the edge after `ack`.

## Operation
- FSM states: IDLE, WAIT, RESP. Counter `cnt` is 4 bits.
- **IDLE:**
  - If `req`=1 at an edge, latch `we`, `be`, `wdata` and word index `addr[ADDR_W+1:2]`.
  - Load `cnt` with LATENCY-1 and go to WAIT.
  - If `req`=0, stay in IDLE.
- **WAIT:**
  - Inputs are ignored.
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`=0, perform the access on the latched values, set `ack`=1 and go to RESP.
  - Store: byte i of the word is replaced only where `be[i]`=1; other bytes keep their value.
  - Load: `rdata` takes the full stored word.
- **RESP:**
  - `ack`=1 for exactly this cycle.
  - `req` is ignored even if still high.
  - The next edge goes to IDLE and clears `ack`.
- Addressing:
  - `addr[1:0]` and the address bits above `ADDR_W+1` are ignored; addresses alias modulo 2^ADDR_W words.
  - No misalignment fault is raised.
- Stores do not change `rdata`; `rdata` holds the last load value until the next load commits.
- `be`=0000 on a store still completes the handshake with memory unchanged.
- A load after a store to the same word returns the merged store data; ordering is strict because only one request is in flight.

## Timing
- Reset (asynchronous):
  - state=IDLE, `cnt`=0, `ack`=0, `busy`=0, `rdata`=0.
  - All memory words are set to 0.
- Accept at edge k, then:
  - Memory commit and `ack` rise at edge k+LATENCY.
  - `ack` falls and `busy` falls at edge k+LATENCY+1.
- `busy` rises at edge k and is a registered output.
- The earliest next accept is edge k+LATENCY+2, with `req` high in the cycle after `ack`.
- Throughput is one request per LATENCY+2 cycles.
- Requester rule: drop `req` in the cycle after seeing `ack`, or hold it for a new request. A `req` still high during RESP is not a new request.
- Reset mid-operation:
  - Before the commit edge, the pending store is discarded and no `ack` is issued.
  - Memory is cleared regardless.
- Reset released in the same cycle as `req`=1: accept occurs at the first rising edge after deassertion.

## Test plan
- Reset, then load addr 0x0000_0010 with LATENCY=2: `ack` at the 2nd edge after accept, `rdata`=0x0000_0000, `busy` high for 3 cycles.
- Store 0xDEADBEEF to 0x0000_0040 with `be`=1111, then load 0x0000_0040: `rdata`=0xDEADBEEF; `ack` pulses exactly once per request.
- Store 0x11223344 with `be`=0101 to a word holding 0xDEADBEEF, then load it: `rdata`=0xDE22BE44.
- Aliasing: store 0x12345678 to 0x0000_1004 (ADDR_W=10), then load 0x0000_0004 and 0x0000_0007: both return 0x12345678.
- `req` held high continuously across two loads: second accept at edge k+4 (LATENCY=2), no ack-cycle re-accept, exactly two `ack` pulses.
- Assert `reset` during WAIT of a store to 0x0000_0020: no `ack`, `busy`=0 immediately, subsequent load of 0x0000_0020 returns 0.
